// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Callers zero-extend narrower words; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
        logic x;
        x = ^data;
        case (mode)
            PAR_ODD:  return ~x;
            PAR_EVEN: return x;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks on the last clk of each serial bit, realigned by clear.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_axis.sv
// UART transmitter fed by an AXI-stream slave, with CTS-gated acceptance.
module uart_tx_axis
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 cts_n,
    output logic                 txd,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 cts_meta_q, cts_s_q;
    logic                 accept;
    logic                 tick;

    assign s_axis_tready = (state_q == IDLE) && !cts_s_q;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Clearing on accept aligns the first bit period to the start bit.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(accept),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shift_d    = s_axis_tdata;
                    par_d      = parity_bit(8'(s_axis_tdata), PAR_MODE);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PAR_MODE != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (int'(stop_idx_q) == STOP_BITS - 1) begin
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // txd is decoded from the next state so the pin itself is a flop.
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PAR:     txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_s_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            cts_meta_q <= cts_n;
            cts_s_q    <= cts_meta_q;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: doc/uart_tx_axis.md
Name: uart_tx_axis

Overview:
Serial UART transmitter with an AXI-stream slave input and RTS/CTS flow control. It is the transmit-direction counterpart of the UART receive path. It accepts bytes from the image data path output stream and serializes them onto txd. Frame format: LSB-first, start bit, DATA_BITS data bits, optional parity, 1 or 2 stop bits.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (CLK_FREQ/BAUD); must be >= 2
DATA_BITS, 8, data bits per frame (5..8); s_axis_tdata width
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_axis_tdata  in  DATA_BITS  byte to transmit
s_axis_tvalid  in  1  source has data
s_axis_tready  out  1  block accepts data this cycle
cts_n  in  1  clear-to-send from peer, active-low, asynchronous
txd  out  1  serial output, idle high
busy  out  1  high from the accept cycle until the last stop bit ends

Behaviour:
- Reset: rst_n sampled on posedge clk only; reset is synchronous, active-low, clock is clk. While rst_n=0: txd=1, s_axis_tready=0, busy=0, state=IDLE, counters cleared, CTS synchronizer set to 1 (not clear).
- Reset mid-frame: the frame is aborted. txd=1 on the first edge with rst_n=0. No partial byte resumes after reset release.
- CTS: cts_n passes through a 2-flop synchronizer, giving cts_s. There are 2 cycles of latency before it affects tready.
- Handshake:
  - s_axis_tready = (state==IDLE) && (cts_s==0). It is a registered-state decode with no combinational path from tvalid.
  - Transfer occurs on a cycle with tvalid && tready. tdata is latched into a shift register; busy=1 from the next edge.
  - tdata and tvalid are ignored when tready=0.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on transfer. txd=0 from the next cycle.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA shifts out LSB first, each bit held CLKS_PER_BIT cycles. After DATA_BITS bits it goes to PAR if PARITY!=0, else to STOP.
  - PAR drives the parity bit for CLKS_PER_BIT cycles, then goes to STOP. Even: XOR of the data bits. Odd: inverted XOR.
  - STOP drives txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then goes to IDLE.
- Bit counter: baud counter width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit index counter holds 0..DATA_BITS-1.
- txd is driven directly from a flop; no glitches are permitted.
- CTS deasserted mid-frame: the current frame completes unchanged. The next transfer is blocked until cts_s=0.
- Back-to-back: the block returns to IDLE for exactly 1 cycle (tready=1 if CTS is allowed), so the frame period is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT + 1 cycles.
- tvalid held while CTS is blocked: no transfer occurs and no bytes are lost. The source holds the data per AXI rules.

Decomposition:
- uart_pkg holds:
  - the state enum tx_state_e {IDLE, START, DATA, PAR, STOP}
  - the parity encoding enum parity_e {PAR_NONE, PAR_ODD, PAR_EVEN}
  - a function parity_bit(data, mode)
- One sub-module: uart_baud_cnt (CLKS_PER_BIT). Inputs are clk, rst_n, and a clear pulse on frame start. Output is a tick pulse on the last cycle of each bit. The receiver reuses it.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with tvalid=1 -> txd=1, tready=0, busy=0 throughout. After release with cts_n=0, tready=1 within 3 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY=0, tdata=0xA5 -> after the accept cycle, txd = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. Total 40 cycles; busy high 40 cycles.
- Parity, CLKS_PER_BIT=4, tdata=0xA5 -> parity bit 0 with even, 1 with odd. tdata=0x01 -> parity bit 1 with even. Frame length 44 cycles.
- Back-to-back: tvalid held with 0x55, then 0x0F -> second start bit begins exactly 41 cycles after the first (PARITY=0, STOP_BITS=1). A scoreboard decodes both bytes correctly.
- Flow control:
  - Set cts_n=1 at mid-frame -> the frame completes intact, then tready stays 0 for 100 cycles with tvalid=1 and txd=1.
  - Set cts_n=0 -> tready rises 2–3 cycles later and the pending byte is sent.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> txd=1 on the next edge. After release, sending 0x3C produces a clean frame decoding to 0x3C.
